vedic_div_arbiter: RTL and testbench
====================================

Name: vedic_div_arbiter

Overview:
Round-robin arbiter and sequencer sharing one cascaded_vedic_divider_16bit instance among NUM_REQ requesters. Accepts one division request at a time, latches its operands, and pulses the divider start. It waits for the divider's done, then returns quotient/remainder on a shared response bus tagged with the requester ID. Divide-by-zero requests are resolved locally and never reach the divider.

Parameters:
WIDTH, 32, operand/result width (matches divider WIDTH)
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), requester ID width
TIMEOUT_CYCLES, 256, WAIT-state limit (used only with DIV_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_dividend  input  NUM_REQ*WIDTH  flattened dividends, requester i at [i*WIDTH +: WIDTH]
req_divisor  input  NUM_REQ*WIDTH  flattened divisors, same packing
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  requester that owns the response
rsp_quotient  output  WIDTH  quotient
rsp_remainder  output  WIDTH  remainder
rsp_dbz  output  1  divide-by-zero flag
rsp_timeout  output  1  divider timeout flag (0 without DIV_TIMEOUT_EN)
div_start  output  1  one-cycle start pulse to divider
div_dividend  output  WIDTH  divider dividend operand
div_divisor  output  WIDTH  divider divisor operand
div_quotient  input  WIDTH  divider quotient
div_remainder  input  WIDTH  divider remainder
div_done  input  1  divider done

Behaviour:
- Clock clk, synchronous active-low reset rst_n; all state updates on rising clk only.
- Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, rsp_*, div_*). Reset mid-operation abandons the in-flight request; no response is issued. The divider shares rst_n.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first req_valid at or after rr_ptr, searching cyclically. req_ready is driven combinationally: one-hot at the grant when state==IDLE, otherwise 0. An accept occurs on req_valid&req_ready. Operands and ID latch on the accept. If divisor==0, go to RESP with rsp_dbz=1, quotient={WIDTH{1'b1}}, remainder=dividend. Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle, then go to WAIT. div_dividend/div_divisor are driven from the latches and held stable through ISSUE and WAIT.
- WAIT: div_done is sampled only in this state. On div_done, capture div_quotient/div_remainder and go to RESP.
- RESP: rsp_valid=1, with rsp_* stable until rsp_valid&rsp_ready. On that handshake: go to IDLE, rr_ptr=grant+1 (mod NUM_REQ), and clear rsp_valid and flags. A new accept can occur in the IDLE cycle after the handshake.
- Latency: accept at cycle T, div_start at T+1, rsp_valid the cycle after div_done is seen. For dbz, rsp_valid at T+1.
- Requesters must hold valid and operands until accepted. Dropping valid before acceptance is legal; that requester loses its turn.
- Single outstanding request; no pipelining.

Optional Feature:
DIV_TIMEOUT_EN:
- Defined: a WAIT cycle counter runs. Reaching TIMEOUT_CYCLES without div_done forces RESP with rsp_timeout=1, quotient=0, remainder=0. A late div_done arriving outside WAIT is ignored.
- Undefined: no counter; WAIT persists until div_done; rsp_timeout is tied to 0.

Decomposition:
- Package vedic_div_pkg: FSM state enum (IDLE/ISSUE/WAIT/RESP), DBZ_QUOTIENT constant (all ones), default WIDTH/NUM_REQ constants.
- One sub-module: vedic_rr_arbiter. Inputs: request vector and rr_ptr. Outputs: one-hot grant, grant index, any_grant. Purely combinational.

Test Plan:
1. Req0 12540000/98 alone -> div_start one cycle after accept; rsp_id=0, quotient=127959, remainder=18, dbz=0.
2. Req2 8610000/700 -> quotient=12300, remainder=0, rsp_id=2.
3. All 4 requesters valid from reset with distinct operands -> grants in order 0,1,2,3. Then req1 and req3 valid together -> grant 1 (rr_ptr=0 after grant 3), then 3.
4. Req1 100/0 -> rsp_valid one cycle after accept, dbz=1, quotient=0xFFFFFFFF, remainder=100, div_start never asserted.
5. rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready all 0. rst_n low during WAIT -> all outputs 0 next cycle, no response issued.
6. DIV_TIMEOUT_EN, TIMEOUT_CYCLES=16, div_done stuck low -> rsp_timeout=1, quotient=0, remainder=0 after 16 WAIT cycles.

Source files
------------

// File: rtl/vedic_div_pkg.sv
// vedic_div_pkg: shared FSM state type, divide-by-zero quotient and default sizes for vedic_div_arbiter
package vedic_div_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam logic [63:0] DBZ_QUOTIENT = '1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/vedic_div_arbiter_if.sv
// vedic_div_arbiter_if: requester, response and divider buses of vedic_div_arbiter
interface vedic_div_arbiter_if
  import vedic_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dividend, req_divisor;
  logic rsp_valid, rsp_ready, rsp_dbz, rsp_timeout;
  logic [ID_W-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_quotient, rsp_remainder;
  logic div_start, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  modport slave (
    input req_valid, req_dividend, req_divisor, rsp_ready, div_quotient, div_remainder, div_done,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout,
    output div_start, div_dividend, div_divisor
  );
  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready, div_quotient, div_remainder, div_done,
    input req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout,
    input div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/vedic_rr_arbiter.sv
// vedic_rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
module vedic_rr_arbiter
  import vedic_div_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o = ID_W'((int'(ptr_i) + k) % N);
        any_o = 1'b1;
      end
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/vedic_div_arbiter.sv
// vedic_div_arbiter: round-robin sequencer sharing one divider among NUM_REQ requesters
// Define DIV_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles without div_done.
module vedic_div_arbiter
  import vedic_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst_n,
  vedic_div_arbiter_if.slave bus
);
  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("vedic_div_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end
  state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic any_gnt, dbz_q, dbz_d, to_q, to_d, expired;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d, op_a, op_b;
  vedic_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i(bus.req_valid), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(gnt_idx), .any_o(any_gnt)
  );
  assign op_a = bus.req_dividend[gnt_idx*WIDTH +: WIDTH];
  assign op_b = bus.req_divisor[gnt_idx*WIDTH +: WIDTH];
`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    cnt_q <= (!rst_n || state_q != WAIT) ? '0 : CW'(cnt_q + 1'b1);
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    q_d = q_q;
    r_d = r_q;
    dbz_d = dbz_q;
    to_d = to_q;
    case (state_q)
      IDLE: if (any_gnt) begin
        id_d = gnt_idx;
        a_d = op_a;
        b_d = op_b;
        q_d = DBZ_QUOTIENT[WIDTH-1:0];
        r_d = op_a;
        dbz_d = op_b == '0;
        state_d = op_b == '0 ? RESP : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (bus.div_done) begin
        q_d = bus.div_quotient;
        r_d = bus.div_remainder;
        state_d = RESP;
      end else if (expired) begin
        q_d = '0;
        r_d = '0;
        to_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        ptr_d = id_q == ID_W'(NUM_REQ - 1) ? '0 : id_q + 1'b1;
        dbz_d = 1'b0;
        to_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      q_q <= '0;
      r_q <= '0;
      dbz_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      q_q <= q_d;
      r_q <= r_d;
      dbz_q <= dbz_d;
      to_q <= to_d;
    end
  assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_id = id_q;
  assign bus.rsp_quotient = q_q;
  assign bus.rsp_remainder = r_q;
  assign bus.rsp_dbz = dbz_q;
  assign bus.rsp_timeout = to_q;
  assign bus.div_start = state_q == ISSUE;
  assign bus.div_dividend = a_q;
  assign bus.div_divisor = b_q;
endmodule

// File: tb/tb_vedic_div_arbiter.sv
// tb_vedic_div_arbiter: table-driven scoreboard bench with a behavioural divider model
module tb_vedic_div_arbiter;
  typedef struct { logic [1:0] id; logic [31:0] a, b, q, r; logic dbz; } vec_t;
  typedef struct { logic [1:0] id; logic [31:0] q, r; logic dbz, to; } exp_t;
  logic clk = 0, rst_n = 0;
  int cyc = 0, checks = 0, failures = 0;
  int start_cnt = 0, start_cyc = -1, done_cyc = -1, div_lat = 2, pend = 0;
  bit div_stuck = 0;
  logic [31:0] ma, mb;
  exp_t sb[$];
  vec_t v[8];
  vedic_div_arbiter_if #(.WIDTH(32), .NUM_REQ(4), .ID_W(2)) bus();
  vedic_div_arbiter #(.WIDTH(32), .NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    bus.div_done = 0;
    bus.div_quotient = 0;
    bus.div_remainder = 0;
    forever begin
      @(negedge clk);
      bus.div_done = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.div_done = 1;
          bus.div_quotient = ma / mb;
          bus.div_remainder = ma % mb;
          done_cyc = cyc;
        end
      end
      if (bus.div_start) begin
        start_cnt++;
        start_cyc = cyc;
        ma = bus.div_dividend;
        mb = bus.div_divisor;
        pend = div_stuck ? 0 : div_lat;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic set_req(input vec_t x, input bit push);
    bus.req_dividend[x.id*32 +: 32] = x.a;
    bus.req_divisor[x.id*32 +: 32] = x.b;
    bus.req_valid[x.id] = 1'b1;
    if (push) sb.push_back('{x.id, x.q, x.r, x.dbz, 1'b0});
  endtask
  task automatic wait_accept(input logic [3:0] exp_gnt, output int acc);
    int n = 0;
    #1;
    while (!(|(bus.req_ready & bus.req_valid)) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_wait", n < 100, 1);
    chk("grant", bus.req_ready, exp_gnt);
    acc = cyc;
  endtask
  task automatic wait_rsp(output int rc);
    int n = 0;
    #1;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rsp_wait", n < 200, 1);
    rc = cyc;
  endtask
  task automatic check_rsp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got response id %0d required none", bus.rsp_id);
    end else begin
      e = sb.pop_front();
      chk("rsp_id", bus.rsp_id, e.id);
      chk("rsp_quotient", bus.rsp_quotient, e.q);
      chk("rsp_remainder", bus.rsp_remainder, e.r);
      chk("rsp_dbz", bus.rsp_dbz, e.dbz);
      chk("rsp_timeout", bus.rsp_timeout, e.to);
    end
  endtask
  task automatic run_one(input vec_t x);
    int acc, rc, s0;
    wait_accept(4'(1) << x.id, acc);
    s0 = start_cnt;
    @(negedge clk);
    bus.req_valid[x.id] = 1'b0;
    wait_rsp(rc);
    if (x.dbz) begin
      chk("dbz_latency", rc, acc + 1);
      chk("dbz_no_start", start_cnt, s0);
    end else begin
      chk("start_latency", start_cyc, acc + 1);
      chk("rsp_latency", rc, done_cyc + 1);
    end
    check_rsp();
    @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_q"}, bus.rsp_quotient, 0);
    chk({tag, "_rsp_r"}, bus.rsp_remainder, 0);
    chk({tag, "_rsp_dbz"}, bus.rsp_dbz, 0);
    chk({tag, "_rsp_to"}, bus.rsp_timeout, 0);
    chk({tag, "_div_start"}, bus.div_start, 0);
    chk({tag, "_div_a"}, bus.div_dividend, 0);
    chk({tag, "_div_b"}, bus.div_divisor, 0);
  endtask
  initial begin
    int acc, rc, n_rsp;
    v[0] = '{2'd0, 32'd12540000, 32'd98, 32'd127959, 32'd18, 1'b0};
    v[1] = '{2'd1, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0};
    v[2] = '{2'd2, 32'd8610000, 32'd700, 32'd12300, 32'd0, 1'b0};
    v[3] = '{2'd3, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
    v[4] = '{2'd1, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1};
    v[5] = '{2'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    v[6] = '{2'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
    v[7] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
    bus.req_valid = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(v[i], 1);
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    for (int i = 0; i < 4; i++) run_one(v[i]);
    set_req(v[1], 1);
    set_req(v[3], 1);
    run_one(v[1]);
    run_one(v[3]);
    for (int i = 0; i < 8; i++) begin
      div_lat = 1 + (i % 4);
      set_req(v[i], 1);
      run_one(v[i]);
    end
    bus.rsp_ready = 1'b0;
    set_req(v[2], 1);
    wait_accept(4'b0100, acc);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    set_req(v[5], 1);
    wait_rsp(rc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_id", bus.rsp_id, 2);
      chk("stall_q", bus.rsp_quotient, 12300);
      chk("stall_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    check_rsp();
    @(negedge clk);
    run_one(v[5]);
    div_stuck = 1;
    set_req(v[1], 0);
    wait_accept(4'b0010, acc);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #1;
    check_zero("midreset");
    rst_n = 1;
    div_stuck = 0;
    n_rsp = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) n_rsp++;
    end
    chk("abandoned_no_rsp", n_rsp, 0);
`ifdef DIV_TIMEOUT_EN
    div_stuck = 1;
    set_req(v[0], 0);
    sb.push_back('{2'd0, 32'd0, 32'd0, 1'b0, 1'b1});
    wait_accept(4'b0001, acc);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    wait_rsp(rc);
    chk("timeout_latency", rc, acc + 18);
    check_rsp();
    @(negedge clk);
    div_stuck = 0;
`endif
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
